mips_hazard_scoreboard: RTL and testbench

Issue-side interlock unit for the next-generation single-clock MIPS32 pipeline. It tracks destination registers of in-flight instructions and stalls decode while a source operand has a pending write. Programs then need no dummy OR instructions between dependent operations. It also squashes wrong-path entries on a taken branch and drains cleanly on HALT.

---
 rtl/mips_pkg.sv | 19 +
 rtl/mips_dest_pipe.sv | 41 ++++
 rtl/mips_hazard_scoreboard.sv | 90 +++++++++
 tb/tb_mips_hazard_scoreboard.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS32 issue interlock.
package mips_pkg;
  localparam int REG_AW = 5;

  localparam logic [5:0] ADD   = 6'h00;
  localparam logic [5:0] ADDI  = 6'h08;
  localparam logic [5:0] SUBI  = 6'h09;
  localparam logic [5:0] BNEQZ = 6'h05;
  localparam logic [5:0] MUL   = 6'h1c;
  localparam logic [5:0] LW    = 6'h23;
  localparam logic [5:0] SW    = 6'h2b;
  localparam logic [5:0] HALT  = 6'h3f;

  // One in-flight destination write.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
  } slot_t;
endpackage

// File: rtl/mips_dest_pipe.sv
// WB_DIST-deep shift register of pending destination writes.
// Slot 0 is youngest; kill applies after the shift.
module mips_dest_pipe
  import mips_pkg::*;
#(
  parameter int WB_DIST  = 3,
  parameter int NUM_REGS = 32
) (
  input  logic                 clk1,
  input  logic                 rst_n,
  input  slot_t                ins,
  input  logic [WB_DIST-1:0]   kill,
  output slot_t [WB_DIST-1:0]  slots,
  output logic [NUM_REGS-1:0]  busy_mask
);

  slot_t [WB_DIST-1:0] nxt;

  // Next slot contents: shift by one, insert at slot 0, then drop killed slots.
  always_comb begin
    nxt    = '0;
    nxt[0] = ins;
    for (int k = 1; k < WB_DIST; k++) nxt[k] = slots[k-1];
    for (int k = 0; k < WB_DIST; k++) if (kill[k]) nxt[k].valid = 1'b0;
  end

  // Slot register; the entry leaving the last slot has reached the register file.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) slots <= '0;
    else        slots <= nxt;
  end

  // OR of one-hot destinations of all valid slots (WAW copies stay busy until the last leaves).
  always_comb begin
    busy_mask = '0;
    for (int k = 0; k < WB_DIST; k++)
      for (int r = 0; r < NUM_REGS; r++)
        if (slots[k].valid && slots[k].rd == REG_AW'(r)) busy_mask[r] = 1'b1;
  end

endmodule

// File: rtl/mips_hazard_scoreboard.sv
// Issue-side interlock: stalls decode on RAW hazards against in-flight
// writes, squashes young slots on a taken branch and drains on HALT.
module mips_hazard_scoreboard
  import mips_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int WB_DIST     = 3,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic                clk1,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_rs,
  input  logic [REG_AW-1:0]   id_rt,
  input  logic                id_rs_used,
  input  logic                id_rt_used,
  input  logic                id_wr_en,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic                id_halt,
  input  logic                br_flush,
  output logic                stall,
  output logic                issue,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                halted,
  output logic                drained,
  output logic [CNT_W-1:0]    stall_count
);

  slot_t [WB_DIST-1:0] slots;
  slot_t               ins;
  logic [WB_DIST-1:0]  kill;
  logic                rs_hit, rt_hit, hazard, any_valid;

  mips_dest_pipe #(.WB_DIST(WB_DIST), .NUM_REGS(NUM_REGS)) u_pipe (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .ins       (ins),
    .kill      (kill),
    .slots     (slots),
    .busy_mask (busy_mask)
  );

  // Operand match. The oldest slot writes the register file on the same edge
  // that clocks a waiting reader out of decode, so it no longer blocks; it
  // still shows as busy until it leaves.
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int k = 0; k < WB_DIST-1; k++) begin
      if (slots[k].valid && slots[k].rd == id_rs) rs_hit = 1'b1;
      if (slots[k].valid && slots[k].rd == id_rt) rt_hit = 1'b1;
    end
  end

  assign hazard = id_valid && ((id_rs_used && id_rs != '0 && rs_hit) ||
                               (id_rt_used && id_rt != '0 && rt_hit));
  assign stall  = hazard && !halted && !br_flush;
  assign issue  = id_valid && !hazard && !halted && !br_flush;

  // Writes to R0 are discarded, so they never occupy a slot.
  assign ins.valid = issue && id_wr_en && (id_rd != '0);
  assign ins.rd    = id_rd;

  // Taken branch: kill the FLUSH_DEPTH youngest post-shift slots (slot 0 is a bubble anyway).
  always_comb begin
    kill = '0;
    for (int k = 1; k < WB_DIST; k++) if (k <= FLUSH_DEPTH) kill[k] = br_flush;
  end

  // Drain detection over every slot, including the one writing back this cycle.
  always_comb begin
    any_valid = 1'b0;
    for (int k = 0; k < WB_DIST; k++) if (slots[k].valid) any_valid = 1'b1;
  end

  assign drained = halted && !any_valid;

  // Sticky halt flag and saturating stall counter.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      halted      <= 1'b0;
      stall_count <= '0;
    end else begin
      if (issue && id_halt) halted <= 1'b1;
      if (stall && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// Scoreboard bench: three configurations share one stimulus stream; a
// queue-of-pending-writes model predicts each cycle's outputs.
module tb_mips_hazard_scoreboard;
  localparam int NI = 3;

  logic       clk1 = 1'b0;
  logic       rst_n;
  logic       id_valid, id_rs_used, id_rt_used, id_wr_en, id_halt, br_flush;
  logic [4:0] id_rs, id_rt, id_rd;

  logic [NI-1:0] o_stall, o_issue, o_halted, o_drained;
  logic [31:0]   o_busy [NI];
  logic [15:0]   o_cnt  [NI];
  logic [15:0]   c3, c4;
  logic [3:0]    c8;

  assign o_cnt[0] = c3;
  assign o_cnt[1] = c4;
  assign o_cnt[2] = {12'd0, c8};

  always #5 clk1 = ~clk1;

  mips_hazard_scoreboard #(.WB_DIST(3), .FLUSH_DEPTH(2), .CNT_W(16)) u3 (
    .clk1(clk1), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en), .id_rd(id_rd),
    .id_halt(id_halt), .br_flush(br_flush), .stall(o_stall[0]), .issue(o_issue[0]),
    .busy_mask(o_busy[0]), .halted(o_halted[0]), .drained(o_drained[0]), .stall_count(c3));

  mips_hazard_scoreboard #(.WB_DIST(4), .FLUSH_DEPTH(2), .CNT_W(16)) u4 (
    .clk1(clk1), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en), .id_rd(id_rd),
    .id_halt(id_halt), .br_flush(br_flush), .stall(o_stall[1]), .issue(o_issue[1]),
    .busy_mask(o_busy[1]), .halted(o_halted[1]), .drained(o_drained[1]), .stall_count(c4));

  mips_hazard_scoreboard #(.WB_DIST(8), .FLUSH_DEPTH(3), .CNT_W(4)) u8 (
    .clk1(clk1), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en), .id_rd(id_rd),
    .id_halt(id_halt), .br_flush(br_flush), .stall(o_stall[2]), .issue(o_issue[2]),
    .busy_mask(o_busy[2]), .halted(o_halted[2]), .drained(o_drained[2]), .stall_count(c8));

  function automatic int wb_of(int i);
    return (i == 0) ? 3 : (i == 1) ? 4 : 8;
  endfunction
  function automatic int fd_of(int i);
    return (i == 2) ? 3 : 2;
  endfunction
  function automatic int cmax_of(int i);
    return (i == 2) ? 15 : 65535;
  endfunction

  // ---------------- reference model ----------------
  // A pending write is {instance, register, edges since issue}. It lands in the
  // register file after wb edges; while fewer than wb edges old it blocks readers.
  typedef struct {
    int inst;
    int rd;
    int age;
  } pw_t;

  typedef struct packed {
    logic [NI-1:0]       stall, issue, halted, drained;
    logic [NI-1:0][31:0] busy;
    logic [NI-1:0][15:0] cnt;
  } exp_t;

  pw_t  pend [$];
  bit   m_halt [NI];
  int   m_cnt  [NI];
  exp_t expq [$];
  exp_t cur;
  bit   have_cur = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic bit blocks(int i, int r);
    foreach (pend[j]) if (pend[j].inst == i && pend[j].rd == r && pend[j].age < wb_of(i)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    pend.delete();
    for (int i = 0; i < NI; i++) begin
      m_halt[i] = 1'b0;
      m_cnt[i]  = 0;
    end
  endtask

  task automatic model_eval(output exp_t e);
    bit haz, any;
    e = '0;
    for (int i = 0; i < NI; i++) begin
      haz = id_valid && ((id_rs_used && id_rs != 0 && blocks(i, int'(id_rs))) ||
                         (id_rt_used && id_rt != 0 && blocks(i, int'(id_rt))));
      e.stall[i] = haz && !m_halt[i] && !br_flush;
      e.issue[i] = id_valid && !haz && !m_halt[i] && !br_flush;
      any = 1'b0;
      foreach (pend[j]) if (pend[j].inst == i) begin
        e.busy[i][pend[j].rd] = 1'b1;
        any = 1'b1;
      end
      e.halted[i]  = m_halt[i];
      e.drained[i] = m_halt[i] && !any;
      e.cnt[i]     = 16'(m_cnt[i]);
    end
  endtask

  task automatic model_edge(input exp_t e);
    pw_t nq [$];
    foreach (pend[j]) begin
      pw_t p;
      p = pend[j];
      p.age++;
      if (p.age <= wb_of(p.inst) && !(br_flush && p.age >= 2 && p.age <= fd_of(p.inst) + 1))
        nq.push_back(p);
    end
    pend = nq;
    for (int i = 0; i < NI; i++) begin
      if (e.issue[i] && id_wr_en && id_rd != 0) pend.push_back('{i, int'(id_rd), 1});
      if (e.issue[i] && id_halt) m_halt[i] = 1'b1;
      if (e.stall[i] && m_cnt[i] < cmax_of(i)) m_cnt[i]++;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: pop the prediction for the current cycle once outputs settle.
  always @(negedge clk1) begin
    exp_t e;
    #2;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("u%0d.stall", i),       32'(o_stall[i]),   32'(e.stall[i]));
        chk($sformatf("u%0d.issue", i),       32'(o_issue[i]),   32'(e.issue[i]));
        chk($sformatf("u%0d.busy_mask", i),   o_busy[i],         e.busy[i]);
        chk($sformatf("u%0d.halted", i),      32'(o_halted[i]),  32'(e.halted[i]));
        chk($sformatf("u%0d.drained", i),     32'(o_drained[i]), 32'(e.drained[i]));
        chk($sformatf("u%0d.stall_count", i), 32'(o_cnt[i]),     32'(e.cnt[i]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic close_cycle();
    if (have_cur) begin
      @(posedge clk1);
      model_edge(cur);
    end
  endtask

  task automatic step(bit v, bit [4:0] rs, bit [4:0] rt, bit rsu, bit rtu,
                      bit we, bit [4:0] rd, bit h, bit fl);
    close_cycle();
    @(negedge clk1);
    id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
    id_wr_en = we; id_rd = rd; id_halt = h; br_flush = fl;
    #1;
    model_eval(cur);
    expq.push_back(cur);
    have_cur = 1'b1;
  endtask

  task automatic bubble();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset pulse between edges, with idle decode inputs.
  task automatic do_reset();
    close_cycle();
    @(negedge clk1);
    id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    id_wr_en = 0; id_rd = 0; id_halt = 0; br_flush = 0;
    rst_n = 1'b0;
    #1;
    model_reset();
    model_eval(cur);
    expq.push_back(cur);
    have_cur = 1'b1;
    chk("rst_busy",  o_busy[0] | o_busy[1] | o_busy[2], 32'h0);
    chk("rst_stall", 32'(o_stall), 32'h0);
    chk("rst_cnt",   32'(o_cnt[0] | o_cnt[1] | o_cnt[2]), 32'h0);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    id_wr_en = 0; id_rd = 0; id_halt = 0; br_flush = 0;
    do_reset();

    // Fill R1..R3, then reset mid-operation.
    step(1, 0, 0, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1, 2, 0, 0);
    step(1, 0, 0, 0, 0, 1, 3, 0, 0);
    bubble();
    chk("fill_busy_u3", o_busy[0], 32'h0000_000e);
    do_reset();

    // RAW back-to-back: ADDI R1 then ADD R4,R1,R2 held in decode.
    step(1, 0, 0, 0, 0, 1, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 2, 1, 1, 1, 4, 0, 0);
      chk("raw_stall_u3", 32'(o_stall[0]), 32'(k < 2));
      chk("raw_issue_u3", 32'(o_issue[0]), 32'(k == 2));
    end
    bubble();
    chk("raw_cnt_u3", 32'(c3), 32'd2);
    do_reset();

    // R0 never hazards; unused operands never hazard.
    step(1, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 1, 1, 3, 0, 0);
    chk("r0_stall", 32'(o_stall), 32'h0);
    step(1, 0, 0, 0, 0, 1, 5, 0, 0);
    step(1, 5, 0, 0, 1, 1, 6, 0, 0);
    chk("unused_stall", 32'(o_stall), 32'h0);
    do_reset();

    // Branch flush after writes to R6, R7, R8.
    step(1, 0, 0, 0, 0, 1, 6, 0, 0);
    step(1, 0, 0, 0, 0, 1, 7, 0, 0);
    step(1, 0, 0, 0, 0, 1, 8, 0, 0);
    step(1, 6, 7, 1, 1, 1, 9, 0, 1);
    chk("flush_issue", 32'(o_issue), 32'h0);
    chk("flush_stall", 32'(o_stall), 32'h0);
    bubble();
    chk("flush_busy_u4", o_busy[1], 32'h0000_0040);
    do_reset();

    // Long dependent chain on R1: the 4-bit counter of the WB_DIST=8 unit saturates.
    step(1, 0, 0, 0, 0, 1, 1, 0, 0);
    repeat (30) step(1, 1, 0, 1, 0, 1, 1, 0, 0);
    bubble();
    chk("sat_cnt_u8", 32'(c8), 32'd15);
    do_reset();

    // HALT drain behind a write to R9.
    step(1, 0, 0, 0, 0, 1, 9, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, 9, 9, 1, 1, 1, 10, 0, 0);
      chk("halt_flag_u3",  32'(o_halted[0]),  32'd1);
      chk("halt_issue_u3", 32'(o_issue[0]),   32'd0);
      chk("halt_stall_u3", 32'(o_stall[0]),   32'd0);
      chk("halt_drain_u3", 32'(o_drained[0]), 32'(k >= 2));
    end
    do_reset();

    // Randomized traffic on a small register window, with periodic resets.
    for (int n = 0; n < 500; n++) begin
      if (n % 125 == 124) do_reset();
      else step($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7,
                5'($urandom_range(0, 7)), $urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0);
    end
    close_cycle();

    for (int w = 0; w < 10 && expq.size() > 0; w++) @(negedge clk1);
    #5;
    if (expq.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d predictions never compared, expected 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
